fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Synchronous single-clock FIFO that generalises the team's basic FIFO.
- Depth may be any integer >= 2, not only a power of two.
- Selectable standard (registered read) or first-word-fall-through (FWFT) output mode.
- Reports occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Sits between streaming producers and consumers in the datapath wherever back-pressure visibility is needed.

Parameters:
- DataWidth, 32, word width in bits (>= 1).
- FifoDepth, 16, number of storage words; any integer >= 2.
- Fwft, 0, 0 = standard mode (data one cycle after read); 1 = FWFT (head word visible whenever o_empty = 0).
- AlmostFullThresh, FifoDepth-2, o_almost_full asserts when count >= this value; legal range 1..FifoDepth.
- AlmostEmptyThresh, 2, o_almost_empty asserts when count <= this value; legal range 0..FifoDepth-1.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- i_rst, in, 1, reset; synchronous, active-high.
- i_write, in, 1, write request.
- i_write_data, in, DataWidth, data written on an accepted write.
- i_read, in, 1, read request (pop).
- i_clear_err, in, 1, synchronous clear of o_overflow and o_underflow.
- o_read_data, out, DataWidth, read data; see Behaviour for timing per mode.
- o_read_valid, out, 1, standard mode: 1-cycle pulse qualifying o_read_data; FWFT: equals !o_empty.
- o_full, out, 1, count == FifoDepth.
- o_empty, out, 1, count == 0.
- o_almost_full, out, 1, count >= AlmostFullThresh.
- o_almost_empty, out, 1, count <= AlmostEmptyThresh.
- o_count, out, $clog2(FifoDepth+1), current occupancy.
- o_overflow, out, 1, sticky: a write was attempted while full.
- o_underflow, out, 1, sticky: a read was attempted while empty.

Behaviour:
- Accept rules: write_en = i_write && !o_full; read_en = i_read && !o_empty. Both use the flags as registered at the start of the cycle.
- Rejected requests are dropped with no state change, except the corresponding sticky error flag is set.
- Pointers: read and write addresses are width $clog2(FifoDepth). Each increments on its enable and wraps from FifoDepth-1 to 0 explicitly (no power-of-two reliance).
- Count: a registered counter.
  - +1 on write_en only; -1 on read_en only; unchanged when both or neither are set.
  - Never exceeds FifoDepth; never goes below 0.
- All status flags are decoded from the count register. They change in the cycle after the accepting edge.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected (o_overflow set), and count decrements.
  - When empty: the write is accepted, the read is rejected (o_underflow set), and count increments.
  - Otherwise: both are accepted and count is unchanged.
- Standard mode (Fwft = 0):
  - On read_en, o_read_data <= mem[read_addr] at that edge, and o_read_valid = 1 for exactly the following cycle.
  - o_read_data holds its value otherwise.
- FWFT mode (Fwft = 1):
  - o_read_data = mem[read_addr] combinationally; it is valid whenever o_empty = 0.
  - A write into an empty FIFO makes the word visible, with o_empty = 0, in the cycle after the write edge.
  - i_read pops the head word; the next word appears the following cycle.
- Memory: written at mem[write_addr] on write_en. Memory contents are not cleared by reset.
- Error flags: o_overflow <= 1 on (i_write && o_full); o_underflow <= 1 on (i_read && o_empty).
  - Cleared by i_rst or i_clear_err.
  - If a clear and a new error occur in the same cycle, the flag ends up set.
- Reset (i_rst = 1 at an edge, including mid-operation):
  - Pointers and count go to 0; o_read_data goes to 0; o_read_valid goes to 0; error flags go to 0.
  - Any i_read/i_write in the reset cycle is ignored.
  - Resulting output values: o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0, o_count = 0.
- Write-data throughput: one write and one read per cycle sustained. A read never returns a word written in the same cycle.

Test Plan:
- Depth 5, standard mode: reset, write 0xA1..0xA5 on 5 consecutive cycles -> o_count = 5, o_full = 1. A 6th write sets o_overflow = 1 and o_count stays 5. Then 5 reads -> o_read_data sequence 0xA1..0xA5, each with a 1-cycle o_read_valid pulse; o_empty = 1 afterwards.
- Depth 5 wrap-around: interleave 12 writes (values 0..11) and reads, keeping occupancy at 1-3 -> read order 0..11 exactly; count never exceeds 3; no error flags set.
- FWFT, depth 16: write 0x55 into an empty FIFO -> next cycle o_empty = 0, o_read_valid = 1, o_read_data = 0x55 with no read issued. Assert i_read -> next cycle o_empty = 1.
- Thresholds: depth 16, AlmostFullThresh = 14, AlmostEmptyThresh = 2.
  - Fill one word at a time: o_almost_empty is 1 for counts 0..2 and deasserts at count 3.
  - o_almost_full asserts at count 14.
- Simultaneous ops: with the FIFO full, assert read and write together -> o_count goes 16 -> 15 and o_overflow = 1. With the FIFO empty, assert both -> o_count = 1 and o_underflow = 1. Pulse i_clear_err -> both flags return to 0.
- Reset mid-stream: with o_count = 7 and a read pending, assert i_rst for 1 cycle -> next cycle o_count = 0, o_empty = 1, o_read_valid = 0, o_read_data = 0. A subsequent write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO of any depth >= 2 with standard or first-word-fall-through output,
// an occupancy count, programmable almost-full/almost-empty flags and sticky error flags.
module fifo_sync_flags #(
    parameter int DataWidth         = 32,
    parameter int FifoDepth         = 16,
    parameter int Fwft              = 0,
    parameter int AlmostFullThresh  = FifoDepth - 2,
    parameter int AlmostEmptyThresh = 2,
    localparam int AddrWidth        = $clog2(FifoDepth),
    localparam int CountWidth       = $clog2(FifoDepth + 1)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_write,
    input  logic [DataWidth-1:0]  i_write_data,
    input  logic                  i_read,
    input  logic                  i_clear_err,
    output logic [DataWidth-1:0]  o_read_data,
    output logic                  o_read_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [CountWidth-1:0] o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    // Request/accept: i_write is taken only when o_full was low at the edge and i_read only
    // when o_empty was low; a refused request changes nothing except its sticky error flag.
    logic [AddrWidth-1:0]  wr_addr;
    logic [AddrWidth-1:0]  rd_addr;
    logic [CountWidth-1:0] count;
    logic                  write_en;
    logic                  read_en;
    logic [DataWidth-1:0]  mem [FifoDepth];

    assign write_en = i_write && !o_full;
    assign read_en  = i_read && !o_empty;

    assign o_count        = count;
    assign o_empty        = (count == '0);
    assign o_full         = (count == CountWidth'(FifoDepth));
    assign o_almost_full  = (count >= CountWidth'(AlmostFullThresh));
    assign o_almost_empty = (count <= CountWidth'(AlmostEmptyThresh));

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr);
        return (addr == AddrWidth'(FifoDepth - 1)) ? '0 : addr + AddrWidth'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
            count   <= '0;
        end else begin
            if (write_en) wr_addr <= next_addr(wr_addr);
            if (read_en)  rd_addr <= next_addr(rd_addr);
            case ({write_en, read_en})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (write_en && !i_rst) mem[wr_addr] <= i_write_data;
    end

    // A new error in the same cycle as a clear wins, so the flag stays set.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_write && o_full)  o_overflow <= 1'b1;
            else if (i_clear_err)   o_overflow <= 1'b0;
            if (i_read && o_empty)  o_underflow <= 1'b1;
            else if (i_clear_err)   o_underflow <= 1'b0;
        end
    end

    if (Fwft != 0) begin : g_fwft
        assign o_read_data  = mem[rd_addr];
        assign o_read_valid = !o_empty;
    end else begin : g_std
        logic [DataWidth-1:0] rd_data_q;
        logic                 rd_valid_q;

        always_ff @(posedge clk) begin
            if (i_rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= read_en;
                if (read_en) rd_data_q <= mem[rd_addr];
            end
        end

        assign o_read_data  = rd_data_q;
        assign o_read_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: depth-5 standard FIFO, depth-16 standard FIFO (thresholds 14/2) and
// depth-16 FWFT FIFO, all driven from one shared set of inputs.
module tb_fifo_sync_flags;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         wr;
    logic [W-1:0] wdata;
    logic         rd;
    logic         clr;

    logic [W-1:0] a_rdata, b_rdata, c_rdata;
    logic         a_rvalid, b_rvalid, c_rvalid;
    logic         a_full, b_full, c_full;
    logic         a_empty, b_empty, c_empty;
    logic         a_af, b_af, c_af;
    logic         a_ae, b_ae, c_ae;
    logic [2:0]   a_count;
    logic [4:0]   b_count, c_count;
    logic         a_ovf, b_ovf, c_ovf;
    logic         a_unf, b_unf, c_unf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    fifo_sync_flags #(.DataWidth(W), .FifoDepth(5), .Fwft(0)) u_a (
        .clk(clk), .i_rst(rst), .i_write(wr), .i_write_data(wdata), .i_read(rd),
        .i_clear_err(clr), .o_read_data(a_rdata), .o_read_valid(a_rvalid), .o_full(a_full),
        .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_unf));

    fifo_sync_flags #(.DataWidth(W), .FifoDepth(16), .Fwft(0), .AlmostFullThresh(14),
                      .AlmostEmptyThresh(2)) u_b (
        .clk(clk), .i_rst(rst), .i_write(wr), .i_write_data(wdata), .i_read(rd),
        .i_clear_err(clr), .o_read_data(b_rdata), .o_read_valid(b_rvalid), .o_full(b_full),
        .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_unf));

    fifo_sync_flags #(.DataWidth(W), .FifoDepth(16), .Fwft(1)) u_c (
        .clk(clk), .i_rst(rst), .i_write(wr), .i_write_data(wdata), .i_read(rd),
        .i_clear_err(clr), .o_read_data(c_rdata), .o_read_valid(c_rvalid), .o_full(c_full),
        .o_empty(c_empty), .o_almost_full(c_af), .o_almost_empty(c_ae), .o_count(c_count),
        .o_overflow(c_ovf), .o_underflow(c_unf));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive the request set, take the edge, leave outputs settled for sampling.
    task automatic do_cycle(input logic w, input logic [W-1:0] d, input logic r,
                            input logic c, input logic rs);
        wr = w; wdata = d; rd = r; clr = c; rst = rs;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] v;
        wr = 1'b0; wdata = '0; rd = 1'b0; clr = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // reset state
        check("a_rst_count", a_count, 0);
        check("a_rst_empty", a_empty, 1);
        check("a_rst_full", a_full, 0);
        check("a_rst_ae", a_ae, 1);
        check("a_rst_af", a_af, 0);
        check("a_rst_rvalid", a_rvalid, 0);
        check("a_rst_rdata", a_rdata, 0);
        check("a_rst_ovf", a_ovf, 0);

        // depth 5 fill, overflow, drain
        for (int i = 0; i < 5; i++) do_cycle(1'b1, W'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        check("a_fill_count", a_count, 5);
        check("a_fill_full", a_full, 1);
        check("a_fill_af", a_af, 1);
        do_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("a_ovf_flag", a_ovf, 1);
        check("a_ovf_count", a_count, 5);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("a_drain_valid", a_rvalid, 1);
            check("a_drain_data", a_rdata, 32'hA1 + i);
        end
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("a_drain_valid_off", a_rvalid, 0);
        check("a_drain_hold", a_rdata, 32'hA5);
        check("a_drain_empty", a_empty, 1);
        check("a_drain_unf", a_unf, 0);

        // depth 5 wrap-around: occupancy kept between 1 and 3
        do_reset();
        begin
            int max_count;
            max_count = 0;
            for (int k = 0; k < 12; k++) begin
                logic do_rd;
                do_rd = !(k < 2 || k == 6);
                exp_q.push_back(W'(k));
                do_cycle(1'b1, W'(k), do_rd, 1'b0, 1'b0);
                if (int'(a_count) > max_count) max_count = int'(a_count);
                if (do_rd) begin
                    v = exp_q.pop_front();
                    check("wrap_valid", a_rvalid, 1);
                    check("wrap_data", a_rdata, v);
                end
            end
            for (int k = 0; k < 3; k++) begin
                do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
                v = exp_q.pop_front();
                check("wrap_tail_data", a_rdata, v);
            end
            check("wrap_max_count", max_count, 3);
            check("wrap_empty", a_empty, 1);
            check("wrap_ovf", a_ovf, 0);
            check("wrap_unf", a_unf, 0);
        end

        // FWFT: word visible without a read, popped by i_read
        do_reset();
        check("c_rst_rvalid", c_rvalid, 0);
        do_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("c_empty_after_wr", c_empty, 0);
        check("c_rvalid_after_wr", c_rvalid, 1);
        check("c_data_after_wr", c_rdata, 32'h55);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("c_empty_after_rd", c_empty, 1);
        check("c_rvalid_after_rd", c_rvalid, 0);

        // thresholds on depth 16 (AF 14, AE 2)
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            do_cycle(1'b1, W'(n), 1'b0, 1'b0, 1'b0);
            check("b_thr_count", b_count, n);
            check("b_thr_ae", b_ae, (n <= 2) ? 1 : 0);
            check("b_thr_af", b_af, (n >= 14) ? 1 : 0);
        end
        check("b_full", b_full, 1);

        // simultaneous read+write while full, then while empty
        do_cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        check("b_sim_full_count", b_count, 15);
        check("b_sim_full_ovf", b_ovf, 1);
        check("b_sim_full_rdata", b_rdata, 32'h01);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("b_drained", b_count, 0);
        check("b_unf_before", b_unf, 0);
        do_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("b_sim_empty_count", b_count, 1);
        check("b_sim_empty_unf", b_unf, 1);
        check("b_sim_empty_rvalid", b_rvalid, 0);
        check("b_ovf_sticky", b_ovf, 1);
        do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("b_clr_ovf", b_ovf, 0);
        check("b_clr_unf", b_unf, 0);

        // reset mid-stream with a read pending
        do_reset();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("b_pre_rst_data", b_rdata, 32'h10);
        check("b_pre_rst_count", b_count, 7);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("b_mid_rst_count", b_count, 0);
        check("b_mid_rst_empty", b_empty, 1);
        check("b_mid_rst_rvalid", b_rvalid, 0);
        check("b_mid_rst_rdata", b_rdata, 0);
        do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("b_post_rst_valid", b_rvalid, 1);
        check("b_post_rst_data", b_rdata, 32'h3C);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
